pipe_stage_skid: RTL
====================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL provide parameter INSTR_W, default 32, instruction field width.
REQ-002 SHALL provide parameter ADDR_W, default 16, PC-plus-1 field width.
REQ-003 SHALL provide parameter SKID_EN, default 1: 1 gives a 2-entry skid buffer, 0 gives a single-entry register with combinational ready.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port flush, input, 1, synchronous discard of all held entries (branch/jump taken).
REQ-007 SHALL have port in_valid, input, 1, upstream (IF) entry valid.
REQ-008 SHALL have port in_ready, output, 1, stage accepts an entry this cycle.
REQ-009 SHALL have port in_pc_plus1, input, ADDR_W, upstream PC+1.
REQ-010 SHALL have port in_instr, input, INSTR_W, upstream instruction.
REQ-011 SHALL have port out_valid, output, 1, downstream (ID) entry valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts (deasserted = stall).
REQ-013 SHALL have port out_pc_plus1, output, ADDR_W, head entry PC+1.
REQ-014 SHALL have port out_instr, output, INSTR_W, head entry instruction.
REQ-015 SHALL have port occupancy, output, 2, number of valid entries held (0..2).

Function
REQ-016 SHALL count a transfer in on in_valid & in_ready, and a transfer out on out_valid & out_ready.
REQ-017 SHALL give 1-cycle latency: an entry accepted at edge N is presented at the outputs after edge N, with no combinational path from in_* data to out_*.
REQ-018 SHALL preserve strict FIFO order; no entry is dropped or duplicated except by flush or rst.
REQ-019 SHALL, with SKID_EN=1, use states EMPTY, ONE and TWO; occupancy SHALL equal 0, 1 or 2 respectively.
REQ-020 SHALL, with SKID_EN=1, set in_ready = (state != TWO), registered-derived only, never a function of out_ready.
REQ-021 SHALL make these transitions: EMPTY->ONE on in; ONE->TWO on in without out; ONE->EMPTY on out without in; ONE stays ONE on simultaneous in and out; TWO->ONE on out.
REQ-022 SHALL, in TWO, present the older entry at the head; after its transfer out, the skid entry SHALL move to the head on the same edge.
REQ-023 SHALL, with SKID_EN=0, set in_ready = !out_valid | out_ready; occupancy SHALL never exceed 1.
REQ-024 SHALL, while out_valid=0, drive out_instr to the NOP constant (all zeros) and out_pc_plus1 to 0, so ID decodes a bubble.
REQ-025 SHALL, on flush, go to EMPTY at the next edge; flush SHALL win over a simultaneous transfer in, which is discarded.
REQ-026 SHALL keep out_* stable while out_valid=1 and out_ready=0 (stall).
REQ-027 SHALL keep in_ready asserted during flush cycles when the state is not TWO; the accepted entry SHALL be discarded.

Reset
REQ-028 SHALL, with rst=1 at a rising edge, set state to EMPTY, out_valid=0, out_instr=0, out_pc_plus1=0, occupancy=0, and clear the skid entry.
REQ-029 SHALL give rst priority over flush and all transfers; a reset mid-stall SHALL discard both entries.
REQ-030 SHALL force in_ready=0 during the cycle rst is asserted.

Structure
REQ-031 SHALL place the state enum (EMPTY/ONE/TWO), the NOP constant and the default INSTR_W/ADDR_W values in shared package pipe_pkg.
REQ-032 SHALL be a single module with no sub-module; both SKID_EN variants SHALL be generate branches.

Verification
REQ-033 SHALL cover streaming: in_valid=1 for 4 cycles with instr 0x11..0x14 and out_ready=1 -> out_instr 0x11..0x14 on consecutive cycles, each one cycle after input, and occupancy stays 1.
REQ-034 SHALL cover stall: 0xA1 and 0xA2 sent while out_ready=0 -> occupancy=2, in_ready=0 and out_instr holds 0xA1; after out_ready=1, 0xA1 then 0xA2 are output.
REQ-035 SHALL cover flush: flush=1 with occupancy=2 plus a simultaneous in_valid of 0xB3 -> next cycle occupancy=0, out_valid=0, out_instr=0, and 0xB3 never appears.
REQ-036 SHALL cover reset: rst=1 mid-stall with occupancy=2 -> next cycle all outputs are 0 and in_ready returns to 1 one cycle after rst falls.
REQ-037 SHALL cover the SKID_EN=0 variant: out_ready=0 while holding 0xC5 -> in_ready=0; setting out_ready=1 with 0xC6 arriving -> in_ready=1 the same cycle and 0xC6 is output next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the IF->ID pipeline register stage.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int INSTR_W_DEF = 32;
    localparam int ADDR_W_DEF  = 16;

    // All-zero instruction word decodes as a bubble in ID.
    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/pipe_stage_skid.sv
// IF->ID pipeline stage: either a 2-entry skid buffer with registered ready,
// or a single register whose ready looks through to the downstream.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter bit SKID_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDR_W-1:0]  in_pc_plus1,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc_plus1,
    output logic [INSTR_W-1:0] out_instr,
    output logic [1:0]         occupancy
);

    // Handshake: a transfer happens on an edge where valid and ready are both
    // high; valid never waits on ready, and held data is stable until taken.
    state_t             state;
    state_t             state_next;
    logic [INSTR_W-1:0] head_instr;
    logic [ADDR_W-1:0]  head_pc;
    logic               in_fire;
    logic               out_fire;

    assign out_valid    = (state != EMPTY);
    assign out_instr    = out_valid ? head_instr : INSTR_W'(NOP_INSTR);
    assign out_pc_plus1 = out_valid ? head_pc : '0;
    assign occupancy    = state;
    assign in_fire      = in_valid & in_ready;
    assign out_fire     = out_valid & out_ready;

    if (SKID_EN) begin : g_skid
        logic [INSTR_W-1:0] skid_instr;
        logic [ADDR_W-1:0]  skid_pc;
        logic [INSTR_W-1:0] head_instr_next;
        logic [ADDR_W-1:0]  head_pc_next;
        logic [INSTR_W-1:0] skid_instr_next;
        logic [ADDR_W-1:0]  skid_pc_next;

        // Ready depends only on held state, breaking the backpressure path.
        assign in_ready = (state != TWO) && !rst;

        always_comb begin
            state_next      = state;
            head_instr_next = head_instr;
            head_pc_next    = head_pc;
            skid_instr_next = skid_instr;
            skid_pc_next    = skid_pc;
            if (flush) begin
                state_next = EMPTY;
            end else begin
                case (state)
                    EMPTY: begin
                        if (in_fire) begin
                            state_next      = ONE;
                            head_instr_next = in_instr;
                            head_pc_next    = in_pc_plus1;
                        end
                    end
                    ONE: begin
                        case ({in_fire, out_fire})
                            2'b10: begin
                                state_next      = TWO;
                                skid_instr_next = in_instr;
                                skid_pc_next    = in_pc_plus1;
                            end
                            2'b01: state_next = EMPTY;
                            2'b11: begin
                                head_instr_next = in_instr;
                                head_pc_next    = in_pc_plus1;
                            end
                            default: state_next = ONE;
                        endcase
                    end
                    TWO: begin
                        // Older entry leaves; the skid entry becomes the head.
                        if (out_fire) begin
                            state_next      = ONE;
                            head_instr_next = skid_instr;
                            head_pc_next    = skid_pc;
                        end
                    end
                    default: state_next = EMPTY;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state      <= EMPTY;
                head_instr <= '0;
                head_pc    <= '0;
                skid_instr <= '0;
                skid_pc    <= '0;
            end else begin
                state      <= state_next;
                head_instr <= head_instr_next;
                head_pc    <= head_pc_next;
                skid_instr <= skid_instr_next;
                skid_pc    <= skid_pc_next;
            end
        end
    end else begin : g_single
        logic [INSTR_W-1:0] head_instr_next;
        logic [ADDR_W-1:0]  head_pc_next;

        assign in_ready = (!out_valid || out_ready) && !rst;

        always_comb begin
            state_next      = state;
            head_instr_next = head_instr;
            head_pc_next    = head_pc;
            if (flush) begin
                state_next = EMPTY;
            end else if (in_fire) begin
                state_next      = ONE;
                head_instr_next = in_instr;
                head_pc_next    = in_pc_plus1;
            end else if (out_fire) begin
                state_next = EMPTY;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state      <= EMPTY;
                head_instr <= '0;
                head_pc    <= '0;
            end else begin
                state      <= state_next;
                head_instr <= head_instr_next;
                head_pc    <= head_pc_next;
            end
        end
    end

endmodule
